dcache_trans_req: RTL
=====================

Name: dcache_trans_req

Overview:
- Requester (master) side of the dcache address-translation interface.
- Accepts one load/store request at a time from the memory pipeline stage and checks its alignment.
- Issues a one-cycle translation fetch (data_fetch/data_vaddr) and captures the returned physical address (ret_data_paddr) after a fixed latency.
- Presents vaddr, paddr and store payload to the dcache lookup stage with a valid/ready handshake; flush support for pipeline cancellation.

Parameters:
- TRANS_LATENCY, 1: cycles from data_fetch-high cycle until ret_data_paddr is valid; legal range 1..7.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  cancel any in-flight request; no result delivered.
- req_valid  in  1  pipeline request valid.
- req_ready  out  1  block can accept; combinational = (state==IDLE) && !flush && rst_n.
- req_vaddr  in  32  virtual address.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- req_wen  in  1  1 = store, 0 = load.
- req_wstrb  in  4  store byte strobes.
- req_wdata  in  32  store data.
- data_fetch  out  1  translation request strobe, registered.
- data_vaddr  out  32  virtual address to translator, registered.
- ret_data_paddr  in  32  physical address from translator.
- out_valid  out  1  result valid, registered.
- out_ready  in  1  dcache stage accepts result.
- out_vaddr  out  32  latched vaddr.
- out_paddr  out  32  translated paddr; 0 when out_ale=1.
- out_ale  out  1  alignment exception.
- out_wen  out  1  latched req_wen.
- out_wstrb  out  4  latched req_wstrb.
- out_wdata  out  32  latched req_wdata.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; wait counter=0.
  - All registered outputs reset to 0: data_fetch, data_vaddr, out_valid, out_vaddr, out_paddr, out_ale, out_wen, out_wstrb, out_wdata.
  - Reset mid-operation discards the request; no out_valid afterwards.
- States: IDLE, FETCH, WAIT, OUT.
- Accept condition: req_valid && req_ready in cycle N. On accept, latch vaddr, size, wen, wstrb and wdata.
- Alignment check on accept:
  - ale = (size==1 && vaddr[0]) || (size>=2 && vaddr[1:0]!=0).
  - ale=1: next state OUT with out_ale=1, out_paddr=0; no data_fetch is issued; out_valid in cycle N+1.
  - ale=0: next state FETCH.
- FETCH (cycle N+1):
  - data_fetch=1 for exactly this one cycle; data_vaddr=latched vaddr.
  - Load counter with TRANS_LATENCY; go to WAIT.
- WAIT:
  - data_fetch=0; data_vaddr holds its value; counter decrements each cycle.
  - When counter==1: capture ret_data_paddr into out_paddr; go to OUT.
  - Net latency for TRANS_LATENCY=L: paddr sampled in cycle N+1+L; out_valid first high in cycle N+2+L (N+3 for L=1).
- OUT:
  - out_valid=1; all out_* stable until out_valid && out_ready.
  - On handshake: out_valid=0 next cycle, state IDLE.
  - req_ready is 0 in OUT, so there is no back-to-back overlap. Sustained throughput is one request per L+3 cycles (ale requests: one per 2 cycles).
- data_fetch is never high outside FETCH; data_vaddr retains its last value in IDLE.
- flush=1 in any state:
  - Next state IDLE; out_valid=0 next cycle; counter cleared.
  - Flush has priority over accept and over the out handshake in the same cycle.
  - Flush during FETCH: data_fetch stays high that cycle; the returned paddr is ignored.
- Unexpected input changes: ret_data_paddr changes outside the sampling cycle are ignored. req_* changes while not accepting are ignored.

Test Plan:
- Aligned word load, L=1, out_ready=1. Bench translator returns {8'hFF, vaddr[23:0]} L cycles after data_fetch. Accept vaddr 0x0012_3454 size=2 at N -> data_fetch=1 only at N+1 with data_vaddr=0x0012_3454; out_valid at N+3 with out_paddr=0xFF12_3454, out_ale=0; req_ready high again at N+4.
- Misaligned half store: vaddr 0x0000_1001, size=1, wstrb=4'b0110, wdata=0xDEAD_BEEF -> no data_fetch; out_valid at N+1 with out_ale=1, out_paddr=0, out_wstrb=4'b0110, out_wdata=0xDEAD_BEEF.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> all out_* stable and req_ready=0 throughout; handshake in the 6th cycle -> out_valid=0 next cycle.
- Flush timing:
  - flush asserted in the FETCH cycle -> data_fetch still 1 that cycle; state IDLE next; no out_valid ever; next request's out_paddr reflects only the new vaddr.
  - flush together with req_valid in IDLE -> req_ready=0; no accept.
- TRANS_LATENCY=3: accept at N, translator response valid at N+4 -> out_valid at N+5. A different ret_data_paddr value driven at N+3 must not be captured.
- Reset mid-WAIT (rst_n=0 for one cycle) -> next cycle all outputs 0 and state IDLE; late ret_data_paddr is ignored; a fresh request completes normally.

Source files
------------

// File: rtl/dcache_trans_req.sv
// Requester side of the dcache address-translation interface: accepts one load/store,
// checks alignment, fetches the physical address and presents the result with valid/ready.
module dcache_trans_req #(
    parameter int unsigned TRANS_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_vaddr,
    input  logic [1:0]  req_size,
    input  logic        req_wen,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_wdata,
    output logic        data_fetch,
    output logic [31:0] data_vaddr,
    input  logic [31:0] ret_data_paddr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_vaddr,
    output logic [31:0] out_paddr,
    output logic        out_ale,
    output logic        out_wen,
    output logic [3:0]  out_wstrb,
    output logic [31:0] out_wdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_OUT
    } state_t;

    localparam logic [2:0] LAT = 3'(TRANS_LATENCY);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] wait_cnt;
    logic       accept;
    logic       ale;
    logic       capture;

    assign req_ready = (state == S_IDLE) && !flush && rst_n;
    assign accept    = req_valid && req_ready;

    // Sizes 2 and 3 both mean word, so size[1] alone selects the word rule.
    assign ale = ((req_size == 2'd1) && req_vaddr[0]) ||
                 (req_size[1] && (req_vaddr[1:0] != 2'b00));

    assign capture = (state == S_WAIT) && (wait_cnt == 3'd1) && !flush;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (accept) state_nxt = ale ? S_OUT : S_FETCH;
                S_FETCH: state_nxt = S_WAIT;
                S_WAIT:  if (wait_cnt == 3'd1) state_nxt = S_OUT;
                S_OUT:   if (out_ready) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt   <= 3'd0;
            data_fetch <= 1'b0;
            data_vaddr <= 32'd0;
            out_valid  <= 1'b0;
            out_vaddr  <= 32'd0;
            out_paddr  <= 32'd0;
            out_ale    <= 1'b0;
            out_wen    <= 1'b0;
            out_wstrb  <= 4'd0;
            out_wdata  <= 32'd0;
        end else begin
            data_fetch <= accept && !ale;
            out_valid  <= (state_nxt == S_OUT);

            if (flush) begin
                wait_cnt <= 3'd0;
            end else if (state == S_FETCH) begin
                wait_cnt <= LAT;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 3'd1;
            end

            if (accept) begin
                if (!ale) begin
                    data_vaddr <= req_vaddr;
                end
                out_vaddr <= req_vaddr;
                out_paddr <= 32'd0;
                out_ale   <= ale;
                out_wen   <= req_wen;
                out_wstrb <= req_wstrb;
                out_wdata <= req_wdata;
            end else if (capture) begin
                out_paddr <= ret_data_paddr;
            end
        end
    end

endmodule
